// File: rtl/adc_pkg.sv
// Shared ADC capture types: sample width, capture-buffer addressing and sequencer states.
package adc_pkg;
  localparam int SAMPLE_W = 14;
  localparam int ADDR_W   = 11;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_REPORT,
    ST_HOLDOFF
  } cap_state_t;
endpackage

// File: rtl/peak_tracker.sv
// Pedestal/peak registers for one pulse and the clamped height derived from them.
module peak_tracker
  import adc_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ped_load,
  input  logic              peak_init,
  input  logic              peak_track,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] height
);

  logic [DATA_W-1:0] pedestal;
  logic [DATA_W-1:0] peak;

  // Baseline above the peak means no pulse, so report zero rather than wrap.
  function automatic logic [DATA_W-1:0] clamp_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    clamp_sub = (diff < 0) ? '0 : diff[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pedestal <= '0;
      peak     <= '0;
    end else begin
      if (ped_load) pedestal <= sample;
      if (peak_init) peak <= sample;
      else if (peak_track && (sample > peak)) peak <= sample;
    end
  end

  assign height = clamp_sub(peak, pedestal);

endmodule

// File: rtl/capture_sequencer.sv
// Trigger-driven capture sequencer: writes one window per event, reports pulse height,
// then enforces a dead time before re-arming.
module capture_sequencer
  import adc_pkg::*;
#(
  parameter int WINDOW_LEN  = 500,
  parameter int PEAK_LEN    = 30,
  parameter int HOLDOFF_LEN = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              continuous,
  input  logic              abort,
  input  logic              trigger_in,
  input  sample_t           signal,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output sample_t           wr_data,
  output sample_t           height,
  output logic              height_valid,
  input  logic              height_ready,
  output logic              busy,
  output logic [15:0]       event_count,
  output logic [7:0]        dropped_count
);

  localparam int HO_W = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WINDOW_LEN - 1);
  localparam logic [ADDR_W-1:0] PEAK_LAST = ADDR_W'(PEAK_LEN - 1);
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF_LEN - 1);

  cap_state_t      state;
  cap_state_t      state_nxt;
  logic [HO_W-1:0] ho_cnt;
  logic            trig_p1;
  logic            trig_rise;
  logic            window_done;
  logic            start;
  logic            capturing;
  logic            accept;

  // wr_addr holds the index of the sample written this cycle; the sample being
  // taken now is wr_addr+1.
  assign window_done  = (wr_addr == LAST_ADDR);
  assign start        = (state == ST_ARMED) && trigger_in && !abort;
  assign capturing    = (state == ST_CAPTURE) && !window_done && !abort;
  assign accept       = (state == ST_REPORT) && height_ready && !abort;
  assign trig_rise    = trigger_in && !trig_p1;
  assign busy         = (state == ST_CAPTURE) || (state == ST_REPORT) || (state == ST_HOLDOFF);
  assign height_valid = (state == ST_REPORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (arm || continuous) state_nxt = ST_ARMED;
        ST_ARMED:   if (trigger_in) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (window_done) state_nxt = ST_REPORT;
        ST_REPORT:  if (height_ready) state_nxt = ST_HOLDOFF;
        ST_HOLDOFF: if (ho_cnt == HO_LAST) state_nxt = continuous ? ST_ARMED : ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stage p1: registered write port, holdoff timer, trigger edge history, counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      ho_cnt        <= '0;
      trig_p1       <= 1'b0;
      event_count   <= '0;
      dropped_count <= '0;
    end else begin
      wr_data <= signal;
      trig_p1 <= trigger_in;
      wr_en   <= start || capturing;
      if (start)          wr_addr <= '0;
      else if (capturing) wr_addr <= wr_addr + 1'b1;
      ho_cnt <= (state == ST_HOLDOFF) ? ho_cnt + 1'b1 : '0;
      if (accept) event_count <= event_count + 1'b1;
      if (trig_rise && busy && (dropped_count != 8'hFF)) dropped_count <= dropped_count + 1'b1;
    end
  end

  peak_tracker #(
    .DATA_W(SAMPLE_W)
  ) u_peak (
    .clk       (clk),
    .reset_n   (reset_n),
    .ped_load  ((state == ST_ARMED) && !trigger_in),
    .peak_init (start),
    .peak_track(capturing && (wr_addr < PEAK_LAST)),
    .sample    (signal),
    .height    (height)
  );

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: table of pulse shapes plus hand-written abort/drop/reset runs.
module tb_capture_sequencer;

  localparam int WIN = 500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        trigger_in = 1'b0;
  logic [13:0] signal = 14'd0;
  logic        height_ready = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [13:0] wr_data;
  logic [13:0] height;
  logic        height_valid;
  logic        busy;
  logic [15:0] event_count;
  logic [7:0]  dropped_count;

  capture_sequencer #(
    .WINDOW_LEN (WIN),
    .PEAK_LEN   (30),
    .HOLDOFF_LEN(64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .continuous   (continuous),
    .abort        (abort),
    .trigger_in   (trigger_in),
    .signal       (signal),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .height       (height),
    .height_valid (height_valid),
    .height_ready (height_ready),
    .busy         (busy),
    .event_count  (event_count),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ped;
    int base;
    int pk_idx;
    int pk_val;
    bit ramp;
    int rdy_dly;
    int exp_h;
  } vec_t;

  vec_t        vecs[5];
  logic [24:0] wq[$];
  int          hq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_ev = 0;
  logic [24:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write-port scoreboard: every strobe must match the oldest pending sample.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL write_unexpected: got addr %0d data %0d, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = wq.pop_front();
        check("wr_addr", {21'd0, wr_addr}, {21'd0, mon_e[24:14]});
        check("wr_data", {18'd0, wr_data}, {18'd0, mon_e[13:0]});
      end
    end
  end

  function automatic int samp(input vec_t r, input int i);
    if (r.ramp && i <= r.pk_idx) return r.ped + (r.pk_val - r.ped) * i / r.pk_idx;
    if (i == r.pk_idx) return r.pk_val;
    return r.base;
  endfunction

  task automatic drive_sample(input int i, input int v, input logic trig, input bit expect_wr);
    logic [10:0] a;
    logic [13:0] d;
    a = i[10:0];
    d = v[13:0];
    signal     = d;
    trigger_in = trig;
    if (expect_wr) wq.push_back({a, d});
  endtask

  task automatic arm_and_settle(input int ped);
    @(negedge clk);
    arm = 1'b1;
    signal = ped[13:0];
    trigger_in = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Called at the negedge the last sample was driven; runs report, handshake and holdoff.
  task automatic finish_report(input int rdy_dly);
    int          k;
    int          cyc;
    logic [13:0] h0;
    bit          hold_ok;
    @(negedge clk);
    signal = 14'd0;
    trigger_in = 1'b0;
    k = 0;
    while (height_valid !== 1'b1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("report_entry", {31'd0, height_valid}, 32'd1);
    if (hq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL height_sb: got height %0d, expected none queued", height);
    end else begin
      check("height", {18'd0, height}, hq.pop_front());
    end
    check("busy_report", {31'd0, busy}, 32'd1);
    h0 = height;
    hold_ok = 1'b1;
    for (int d = 0; d < rdy_dly; d++) begin
      @(negedge clk);
      if (height_valid !== 1'b1 || height !== h0) hold_ok = 1'b0;
    end
    if (rdy_dly > 0) check("hold_valid_stable", {31'd0, hold_ok}, 32'd1);
    height_ready = 1'b1;
    @(negedge clk);
    height_ready = 1'b0;
    exp_ev++;
    check("valid_after_hs", {31'd0, height_valid}, 32'd0);
    check("event_count", {16'd0, event_count}, exp_ev);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      arm = (cyc == 10);
      @(negedge clk);
    end
    arm = 1'b0;
    check("holdoff_len", cyc, 32'd64);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ped: 100, base: 300, pk_idx: 10, pk_val: 900,   ramp: 1'b1, rdy_dly: 0,  exp_h: 800};
    vecs[1] = '{ped: 100, base: 700, pk_idx: 30, pk_val: 1200,  ramp: 1'b0, rdy_dly: 20, exp_h: 600};
    vecs[2] = '{ped: 500, base: 400, pk_idx: 0,  pk_val: 400,   ramp: 1'b0, rdy_dly: 0,  exp_h: 0};
    vecs[3] = '{ped: 0,   base: 5,   pk_idx: 29, pk_val: 16383, ramp: 1'b0, rdy_dly: 3,  exp_h: 16383};
    vecs[4] = '{ped: 200, base: 100, pk_idx: 0,  pk_val: 201,   ramp: 1'b0, rdy_dly: 1,  exp_h: 1};

    // Reset values, with a live input that must not reach wr_data.
    signal = 14'd123;
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {21'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {18'd0, wr_data}, 32'd0);
    check("rst_height", {18'd0, height}, 32'd0);
    check("rst_height_valid", {31'd0, height_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_event_count", {16'd0, event_count}, 32'd0);
    check("rst_dropped", {24'd0, dropped_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      arm_and_settle(vecs[v].ped);
      hq.push_back(vecs[v].exp_h);
      for (int i = 0; i < WIN; i++) begin
        if (i > 0) @(negedge clk);
        drive_sample(i, samp(vecs[v], i), (i == 0), 1'b1);
      end
      finish_report(vecs[v].rdy_dly);
      check("writes_drained", wq.size(), 32'd0);
      check("dropped_none", {24'd0, dropped_count}, 32'd0);
    end

    // Continuous mode with three extra trigger pulses mid-window.
    @(negedge clk);
    continuous = 1'b1;
    signal = 14'd200;
    @(negedge clk);
    repeat (2) @(negedge clk);
    hq.push_back(0);
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) @(negedge clk);
      drive_sample(i, 200, (i == 0 || i == 50 || i == 100 || i == 150), 1'b1);
    end
    finish_report(0);
    check("dropped_three", {24'd0, dropped_count}, 32'd3);

    // Re-armed by continuous: trigger immediately, then abort at wr_addr 250.
    drive_sample(0, 1000, 1'b1, 1'b1);
    @(negedge clk);
    check("rearm_wr_en", {31'd0, wr_en}, 32'd1);
    check("rearm_wr_addr", {21'd0, wr_addr}, 32'd0);
    drive_sample(1, 1001, 1'b1, 1'b1);
    for (int i = 2; i <= 250; i++) begin
      @(negedge clk);
      drive_sample(i, 1000 + i, 1'b1, 1'b1);
    end
    @(negedge clk);
    check("abort_at_addr", {21'd0, wr_addr}, 32'd250);
    abort = 1'b1;
    arm = 1'b1;
    continuous = 1'b0;
    trigger_in = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    arm = 1'b0;
    check("abort_wr_en", {31'd0, wr_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, height_valid}, 32'd0);
    check("abort_event_count", {16'd0, event_count}, exp_ev);
    @(negedge clk);
    check("abort_beats_arm", {31'd0, busy}, 32'd0);

    // Trigger toggling through capture and report: dropped_count saturates.
    arm_and_settle(1000);
    for (int k = 0; k < 620; k++) begin
      if (k > 0) @(negedge clk);
      drive_sample(k, 1000, (k % 2 == 0), (k < WIN));
    end
    @(negedge clk);
    trigger_in = 1'b0;
    check("dropped_sat", {24'd0, dropped_count}, 32'd255);
    check("report_waiting", {31'd0, height_valid}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rep_busy", {31'd0, busy}, 32'd0);
    check("abort_rep_valid", {31'd0, height_valid}, 32'd0);
    check("abort_rep_events", {16'd0, event_count}, exp_ev);
    check("dropped_kept", {24'd0, dropped_count}, 32'd255);

    // Trigger already high when ARMED is entered, then reset mid-capture.
    arm = 1'b1;
    trigger_in = 1'b1;
    signal = 14'd77;
    @(negedge clk);
    arm = 1'b0;
    drive_sample(0, 77, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      drive_sample(i, 77 + i, 1'b1, 1'b1);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_wr_addr", {21'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {18'd0, wr_data}, 32'd0);
    check("mid_rst_height", {18'd0, height}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_events", {16'd0, event_count}, 32'd0);
    check("mid_rst_dropped", {24'd0, dropped_count}, 32'd0);
    check("final_writes_drained", wq.size(), 32'd0);
    check("final_heights_drained", hq.size(), 32'd0);
    trigger_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
